// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: buffers CPU writes and launches them one at a time
// through the tx_start/tx_data/tx_avai handshake, with level and overflow status.
module uart_tx_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr,
  input  logic          tx_avai,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          idle
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned PW    = AW + 1;

  typedef enum logic [1:0] {
    L_IDLE   = 2'd0,
    L_LAUNCH = 2'd1,
    L_BUSY   = 2'd2
  } l_state_e;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   wptr_nxt;
  logic [AW:0]   rptr_nxt;
  logic          push;
  logic          pop;
  l_state_e      state;
  l_state_e      state_nxt;
  logic          tx_start_nxt;
  logic [7:0]    tx_data_nxt;

  // Full is judged on pre-edge state, so a same-cycle pop never frees room for this push.
  assign push = wr_en & ~full & ~clr;

  // Launcher next-state and launch decision.
  always_comb begin
    state_nxt    = state;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    pop          = 1'b0;
    case (state)
      L_IDLE: begin
        if (!empty && tx_avai && !clr) begin
          pop          = 1'b1;
          tx_start_nxt = 1'b1;
          tx_data_nxt  = mem[rptr[AW-1:0]];
          state_nxt    = L_LAUNCH;
        end
      end
      L_LAUNCH: state_nxt = L_BUSY;
      L_BUSY: begin
        if (tx_avai) state_nxt = L_IDLE;
      end
      default: state_nxt = L_IDLE;
    endcase
  end

  // Pointer update; flush wins over push and pop.
  always_comb begin
    wptr_nxt = wptr + PW'(push);
    rptr_nxt = rptr + PW'(pop);
    if (clr) begin
      wptr_nxt = '0;
      rptr_nxt = '0;
    end
  end

  // Status is registered from the next pointers so it always matches them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      count    <= wptr_nxt - rptr_nxt;
      empty    <= (wptr_nxt == rptr_nxt);
      full     <= (wptr_nxt[AW] != rptr_nxt[AW]) &&
                  (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
      if (clr) begin
        overflow <= 1'b0;
      end else if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= L_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
    end
  end

  // Live transmitter readiness is part of the drained condition, so this one is combinational.
  assign idle = empty & (state == L_IDLE) & tx_avai;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a minimal uart_tx handshake emulator.
module tb_uart_tx_fifo;

  localparam int unsigned AW = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        clr;
  logic        avai_en;
  logic        tx_avai;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [AW:0] count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        idle;

  int unsigned busy_len = 4;
  int unsigned busy_cnt = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  got [$];
  int          n_starts   = 0;
  int          short_gaps = 0;
  int          cyc        = 0;
  int          last_start = 0;

  uart_tx_fifo #(.AW(AW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr      (clr),
    .tx_avai  (tx_avai),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: drops tx_avai the cycle after tx_start for busy_len cycles.
  assign tx_avai = avai_en & (busy_cnt == 0);
  always @(posedge clk) begin
    if (tx_start && busy_len != 0) busy_cnt <= busy_len;
    else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
  end

  // Launch monitor: records launched bytes and launches closer than 3 cycles apart.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) begin
      got.push_back(tx_data);
      if (n_starts > 0 && (cyc - last_start) < 3) short_gaps <= short_gaps + 1;
      last_start <= cyc;
      n_starts   <= n_starts + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = first + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int k = 0;
    while (!idle && k < max_cyc) begin
      tick();
      k++;
    end
    check(tag, 32'(idle), 32'd1);
  endtask

  task automatic check_seq(input string tag, input int base, input logic [7:0] first, input int n);
    check($sformatf("%s_len", tag), 32'(got.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      logic [7:0] exp_b;
      logic [31:0] act_b;
      exp_b = first + 8'(i);
      act_b = (base + i < got.size()) ? 32'(got[base + i]) : 32'hDEAD;
      check($sformatf("%s[%0d]", tag, i), act_b, 32'(exp_b));
    end
  endtask

  initial begin
    int base;
    int starts_at;
    rstn    = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    clr     = 1'b0;
    avai_en = 1'b1;
    #2 rstn = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_idle",     32'(idle),     32'd1);
    rstn = 1'b1;
    tick();

    // 1: single byte, 2-cycle latency
    base    = got.size();
    wr_en   = 1'b1;
    wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    check("t1_count1",  32'(count),    32'd1);
    check("t1_empty0",  32'(empty),    32'd0);
    check("t1_nostart", 32'(tx_start), 32'd0);
    tick();
    check("t1_start",   32'(tx_start), 32'd1);
    check("t1_data",    32'(tx_data),  32'h55);
    check("t1_count0",  32'(count),    32'd0);
    check("t1_empty1",  32'(empty),    32'd1);
    tick();
    check("t1_pulse",   32'(tx_start), 32'd0);
    wait_idle("t1_idle", 100);
    check_seq("t1_seq", base, 8'h55, 1);

    // 2: fill to full while transmitter busy, then overflow, then drain
    avai_en = 1'b0;
    busy_len = 2;
    base = got.size();
    push_seq(8'h01, 16);
    check("t2_full",     32'(full),     32'd1);
    check("t2_count16",  32'(count),    32'd16);
    check("t2_ovf0",     32'(overflow), 32'd0);
    check("t2_nolaunch", 32'(got.size() - base), 32'd0);
    push_seq(8'h99, 1);
    check("t2_ovf1",     32'(overflow), 32'd1);
    check("t2_count_ovf", 32'(count),   32'd16);
    avai_en = 1'b1;
    wait_idle("t2_idle", 300);
    check_seq("t2_seq", base, 8'h01, 16);
    check("t2_ovf_sticky", 32'(overflow), 32'd1);

    // 3/4: simultaneous push+pop at count 5, then steady stream across pointer wrap
    avai_en = 1'b0;
    busy_len = 0;
    base = got.size();
    push_seq(8'h20, 5);
    check("t3_count5", 32'(count), 32'd5);
    avai_en = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h25;
    tick();
    wr_en = 1'b0;
    check("t3_pp_count", 32'(count),    32'd5);
    check("t3_pp_start", 32'(tx_start), 32'd1);
    check("t3_pp_data",  32'(tx_data),  32'h20);
    starts_at = n_starts;
    for (int i = 0; i < 27; i++) begin
      push_seq(8'h26 + 8'(i), 1);
      tick();
      tick();
    end
    wait_idle("t4_idle", 400);
    check_seq("t3_seq", base, 8'h20, 33);
    check("t4_short_gaps", 32'(short_gaps), 32'd0);
    check("t4_ovf_kept", 32'(overflow), 32'd1);

    // 5: flush with 8 queued and one in flight, same-cycle push discarded
    busy_len = 20;
    base = got.size();
    push_seq(8'h60, 9);
    check("t5_count8", 32'(count),    32'd8);
    check("t5_ovf1",   32'(overflow), 32'd1);
    clr     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    tick();
    clr   = 1'b0;
    wr_en = 1'b0;
    check("t5_count0", 32'(count),    32'd0);
    check("t5_empty",  32'(empty),    32'd1);
    check("t5_ovf0",   32'(overflow), 32'd0);
    starts_at = n_starts;
    wait_idle("t5_idle", 100);
    repeat (5) tick();
    check("t5_no_more", 32'(n_starts - starts_at), 32'd0);
    check_seq("t5_seq", base, 8'h60, 1);

    // 6: async reset mid-busy with 3 queued
    push_seq(8'h70, 4);
    tick();
    tick();
    check("t6_pre_count", 32'(count),   32'd3);
    check("t6_pre_data",  32'(tx_data), 32'h70);
    #2 rstn = 1'b0;
    #1;
    check("t6_count",    32'(count),    32'd0);
    check("t6_empty",    32'(empty),    32'd1);
    check("t6_full",     32'(full),     32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_tx_start", 32'(tx_start), 32'd0);
    check("t6_tx_data",  32'(tx_data),  32'd0);
    #2 rstn = 1'b1;
    starts_at = n_starts;
    repeat (4) tick();
    check("t6_no_launch", 32'(n_starts - starts_at), 32'd0);
    check("t6_post_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
